// File: rtl/ex_mm_forward.sv
// rtl/ex_mm_forward.sv - EX->MM->WB pipeline registers and registered EX operand forwarding selects
module ex_mm_forward #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          ex_valid,
  input  logic          ex_flush,
  input  logic [AW-1:0] ex_dest,
  input  logic [2:0]    ex_wr,
  input  logic          ex_load,
  input  logic          result_P,
  input  logic [31:0]   result_I,
  input  logic [31:0]   result_F,
  input  logic [31:0]   Wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          id_adv,
  input  logic [6*AW-1:0] id_src,
  input  logic [1:0]    id_sel,
  output logic          pval_mm,
  output logic [31:0]   rval_mm,
  output logic [31:0]   fval_mm,
  output logic [31:0]   wdata_mm,
  output logic [31:0]   rval_wb,
  output logic [AW-1:0] wb_dest,
  output logic [2:0]    wb_wr,
  output logic          p1_mux,
  output logic          p2_mux,
  output logic          f1_mux,
  output logic          f2_mux,
  output logic [1:0]    r1_mux,
  output logic [1:0]    r2_mux
);

  localparam int FP = 0;
  localparam int FR = 1;
  localparam int FF = 2;

  logic          mm_valid_q, mm_valid_d;
  logic          mm_load_q, mm_load_d;
  logic [AW-1:0] mm_dest_q, mm_dest_d;
  logic [2:0]    mm_wr_q, mm_wr_d;
  logic          pval_mm_q, pval_mm_d;
  logic [31:0]   rval_mm_q, rval_mm_d;
  logic [31:0]   fval_mm_q, fval_mm_d;
  logic [31:0]   wdata_mm_q, wdata_mm_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_dest_q, wb_dest_d;
  logic [2:0]    wb_wr_q, wb_wr_d;
  logic [31:0]   rval_wb_q, rval_wb_d;
  logic          p1_q, p1_d, p2_q, p2_d, f1_q, f1_d, f2_q, f2_d;
  logic [1:0]    r1_q, r1_d, r2_q, r2_d;

  logic          ex_ok;
  logic [AW-1:0] src_py, src_px, src_ry, src_rx, src_fy, src_fx;

  assign ex_ok = ex_valid & ~ex_flush;
  assign {src_py, src_px, src_ry, src_rx, src_fy, src_fx} = id_src;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [AW-1:0] dst, input logic [AW-1:0] src);
    return v & wr & (dst == src);
  endfunction

  // Integer selects: EX (youngest) beats MM; loads in EX have no data yet; r0 is constant zero.
  function automatic logic [1:0] rsel(input logic use_alt, input logic [AW-1:0] src,
                                      input logic ex_v, input logic [2:0] ewr, input logic [AW-1:0] edst,
                                      input logic mm_v, input logic [2:0] mwr, input logic [AW-1:0] mdst);
    if (use_alt)                                        return 2'b11;
    else if (src != '0 && hit(ex_v, ewr[FR], edst, src)) return 2'b01;
    else if (src != '0 && hit(mm_v, mwr[FR], mdst, src)) return 2'b10;
    else                                                return 2'b00;
  endfunction

  always_comb begin
    mm_valid_d = mm_valid_q;
    mm_load_d  = mm_load_q;
    mm_dest_d  = mm_dest_q;
    mm_wr_d    = mm_wr_q;
    pval_mm_d  = pval_mm_q;
    rval_mm_d  = rval_mm_q;
    fval_mm_d  = fval_mm_q;
    wdata_mm_d = wdata_mm_q;
    wb_valid_d = wb_valid_q;
    wb_dest_d  = wb_dest_q;
    wb_wr_d    = wb_wr_q;
    rval_wb_d  = rval_wb_q;
    p1_d = p1_q; p2_d = p2_q; f1_d = f1_q; f2_d = f2_q;
    r1_d = r1_q; r2_d = r2_q;
    if (!stall) begin
      mm_valid_d = ex_ok;
      mm_load_d  = ex_load;
      mm_dest_d  = ex_dest;
      mm_wr_d    = ex_ok ? ex_wr : 3'b000;
      pval_mm_d  = result_P;
      rval_mm_d  = result_I;
      fval_mm_d  = result_F;
      wdata_mm_d = Wdata;
      wb_valid_d = mm_valid_q;
      wb_dest_d  = mm_dest_q;
      wb_wr_d    = mm_wr_q;
      if (mm_load_q)        rval_wb_d = mem_rdata;
      else if (mm_wr_q[FR]) rval_wb_d = rval_mm_q;
      else if (mm_wr_q[FF]) rval_wb_d = fval_mm_q;
      else                  rval_wb_d = {31'b0, pval_mm_q};
      if (id_adv) begin
        r1_d = rsel(id_sel[1], src_ry, ex_ok & ~ex_load, ex_wr, ex_dest, mm_valid_q, mm_wr_q, mm_dest_q);
        r2_d = rsel(id_sel[0], src_rx, ex_ok & ~ex_load, ex_wr, ex_dest, mm_valid_q, mm_wr_q, mm_dest_q);
        p1_d = hit(ex_ok, ex_wr[FP], ex_dest, src_py);
        p2_d = hit(ex_ok, ex_wr[FP], ex_dest, src_px);
        f1_d = hit(ex_ok, ex_wr[FF], ex_dest, src_fy);
        f2_d = hit(ex_ok, ex_wr[FF], ex_dest, src_fx);
      end else begin
        r1_d = 2'b00; r2_d = 2'b00;
        p1_d = 1'b0; p2_d = 1'b0; f1_d = 1'b0; f2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_valid_q <= 1'b0;
      mm_load_q  <= 1'b0;
      mm_dest_q  <= '0;
      mm_wr_q    <= 3'b000;
      pval_mm_q  <= 1'b0;
      rval_mm_q  <= 32'b0;
      fval_mm_q  <= 32'b0;
      wdata_mm_q <= 32'b0;
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_wr_q    <= 3'b000;
      rval_wb_q  <= 32'b0;
      p1_q <= 1'b0; p2_q <= 1'b0; f1_q <= 1'b0; f2_q <= 1'b0;
      r1_q <= 2'b00; r2_q <= 2'b00;
    end else begin
      mm_valid_q <= mm_valid_d;
      mm_load_q  <= mm_load_d;
      mm_dest_q  <= mm_dest_d;
      mm_wr_q    <= mm_wr_d;
      pval_mm_q  <= pval_mm_d;
      rval_mm_q  <= rval_mm_d;
      fval_mm_q  <= fval_mm_d;
      wdata_mm_q <= wdata_mm_d;
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_wr_q    <= wb_wr_d;
      rval_wb_q  <= rval_wb_d;
      p1_q <= p1_d; p2_q <= p2_d; f1_q <= f1_d; f2_q <= f2_d;
      r1_q <= r1_d; r2_q <= r2_d;
    end
  end

  assign pval_mm  = pval_mm_q;
  assign rval_mm  = rval_mm_q;
  assign fval_mm  = fval_mm_q;
  assign wdata_mm = wdata_mm_q;
  assign rval_wb  = rval_wb_q;
  assign wb_dest  = wb_dest_q;
  assign wb_wr    = wb_valid_q ? wb_wr_q : 3'b000;
  assign p1_mux   = p1_q;
  assign p2_mux   = p2_q;
  assign f1_mux   = f1_q;
  assign f2_mux   = f2_q;
  assign r1_mux   = r1_q;
  assign r2_mux   = r2_q;

endmodule

// File: tb/tb_ex_mm_forward.sv
// tb/tb_ex_mm_forward.sv - directed table-driven bench for ex_mm_forward
module tb_ex_mm_forward;

  localparam int AW = 6;
  localparam logic [31:0] RDATA = 32'hCAFEF00D;

  logic          clk = 1'b0;
  logic          rst_n, stall, ex_valid, ex_flush, ex_load, result_P, id_adv;
  logic [AW-1:0] ex_dest;
  logic [2:0]    ex_wr;
  logic [31:0]   result_I, result_F, Wdata, mem_rdata;
  logic [6*AW-1:0] id_src;
  logic [1:0]    id_sel;
  logic          pval_mm, p1_mux, p2_mux, f1_mux, f2_mux;
  logic [31:0]   rval_mm, fval_mm, wdata_mm, rval_wb;
  logic [AW-1:0] wb_dest;
  logic [2:0]    wb_wr;
  logic [1:0]    r1_mux, r2_mux;

  int n_chk = 0;
  int n_fail = 0;

  ex_mm_forward #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_dest(ex_dest), .ex_wr(ex_wr), .ex_load(ex_load), .result_P(result_P),
    .result_I(result_I), .result_F(result_F), .Wdata(Wdata), .mem_rdata(mem_rdata),
    .id_adv(id_adv), .id_src(id_src), .id_sel(id_sel),
    .pval_mm(pval_mm), .rval_mm(rval_mm), .fval_mm(fval_mm), .wdata_mm(wdata_mm),
    .rval_wb(rval_wb), .wb_dest(wb_dest), .wb_wr(wb_wr),
    .p1_mux(p1_mux), .p2_mux(p2_mux), .f1_mux(f1_mux), .f2_mux(f2_mux),
    .r1_mux(r1_mux), .r2_mux(r2_mux)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ev; int ef; int ed; int ew; int el; logic [31:0] res;
    int adv; int py; int px; int ry; int rx; int fy; int fx; int sel;
    int r1; int r2; int p1; int p2; int f1; int f2;
    logic [31:0] e_rmm; int chk_wb; logic [31:0] e_rwb; int e_wwr; int e_wdest;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input int ev, input int ef, input int ed, input int ew,
                          input int el, input logic [31:0] res);
    ex_valid = 1'(ev); ex_flush = 1'(ef); ex_dest = 6'(ed); ex_wr = 3'(ew);
    ex_load = 1'(el); result_I = res; result_P = res[0]; result_F = ~res;
    Wdata = res ^ 32'hA5A5A5A5;
  endtask

  task automatic drive_id(input int adv, input int py, input int px, input int ry,
                          input int rx, input int fy, input int fx, input int sel);
    id_adv = 1'(adv); id_sel = 2'(sel);
    id_src = {6'(py), 6'(px), 6'(ry), 6'(rx), 6'(fy), 6'(fx)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mux(input string tag, input int r1, input int r2, input int p1,
                         input int p2, input int f1, input int f2);
    chk({tag, ".r1_mux"}, 32'(r1_mux), 32'(r1));
    chk({tag, ".r2_mux"}, 32'(r2_mux), 32'(r2));
    chk({tag, ".pf_mux"}, 32'({p1_mux, p2_mux, f1_mux, f2_mux}),
        32'({1'(p1), 1'(p2), 1'(f1), 1'(f2)}));
  endtask

  initial begin
    //        ev ef ed ew    el res           adv py px ry rx fy fx sel r1 r2 p1 p2 f1 f2 rmm           cw rwb           wwr dst
    vecs[0]  = '{1, 0, 5, 2, 0, 32'h1234,     1, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h1234,     1, 32'h0,        0, 0};
    vecs[1]  = '{1, 0, 5, 2, 0, 32'h5678,     1, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h5678,     1, 32'h1234,     2, 5};
    vecs[2]  = '{1, 0, 6, 2, 0, 32'h9,        1, 0, 0, 0, 5, 0, 0, 0, 0, 2, 0, 0, 0, 0, 32'h9,        1, 32'h5678,     2, 5};
    vecs[3]  = '{1, 0, 7, 2, 0, 32'h77,       1, 0, 0, 7, 6, 0, 0, 2, 3, 2, 0, 0, 0, 0, 32'h77,       1, 32'h9,        2, 6};
    vecs[4]  = '{1, 0, 0, 2, 0, 32'h55,       1, 0, 0, 0, 7, 0, 0, 0, 0, 2, 0, 0, 0, 0, 32'h55,       1, 32'h77,       2, 7};
    vecs[5]  = '{1, 0, 8, 2, 1, 32'h100,      1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100,      1, 32'h55,       2, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 8, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 32'h0,        1, RDATA,        2, 8};
    vecs[7]  = '{1, 1, 3, 4, 0, 32'h3,        1, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 32'h3,        1, 32'h0,        0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 3};
    vecs[9]  = '{1, 0, 3, 4, 0, 32'h40,       1, 0, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0, 1, 0, 32'h40,       1, 32'h0,        0, 0};
    vecs[10] = '{1, 0, 2, 1, 0, 32'h1,        1, 2, 2, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 32'h1,        1, 32'hFFFFFFBF, 4, 3};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1,        1, 2};

    rst_n = 1'b0; stall = 1'b0; mem_rdata = RDATA;
    drive_ex(1, 0, 5, 2, 0, 32'h1234);
    drive_id(1, 0, 0, 5, 5, 0, 0, 0);

    // Reset held with live traffic: nothing may leak out.
    for (int i = 0; i < 4; i++) begin
      drive_ex(1, 0, i + 1, 2, 0, 32'h100 + 32'(i));
      drive_id(1, 0, 0, i + 1, i + 1, 0, 0, 0);
      step();
      chk("reset.wb_wr", 32'(wb_wr), 32'h0);
      chk("reset.rval_wb", rval_wb, 32'h0);
      chk("reset.rval_mm", rval_mm, 32'h0);
      chk_mux("reset", 0, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive_ex(vecs[i].ev, vecs[i].ef, vecs[i].ed, vecs[i].ew, vecs[i].el, vecs[i].res);
      drive_id(vecs[i].adv, vecs[i].py, vecs[i].px, vecs[i].ry, vecs[i].rx,
               vecs[i].fy, vecs[i].fx, vecs[i].sel);
      step();
      chk_mux(tag, vecs[i].r1, vecs[i].r2, vecs[i].p1, vecs[i].p2, vecs[i].f1, vecs[i].f2);
      chk({tag, ".rval_mm"}, rval_mm, vecs[i].e_rmm);
      chk({tag, ".wb_wr"}, 32'(wb_wr), 32'(vecs[i].e_wwr));
      if (vecs[i].e_wwr != 0) chk({tag, ".wb_dest"}, 32'(wb_dest), 32'(vecs[i].e_wdest));
      if (vecs[i].chk_wb != 0) chk({tag, ".rval_wb"}, rval_wb, vecs[i].e_rwb);
    end

    // Stall for 7 cycles with the inputs churning: every output frozen.
    drive_ex(1, 0, 10, 2, 0, 32'h2222);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive_ex(1, 0, 9, 2, 0, 32'h1111);
    drive_id(1, 0, 0, 9, 10, 0, 0, 0);
    step();
    chk_mux("prestall", 1, 2, 0, 0, 0, 0);
    chk("prestall.rval_wb", rval_wb, 32'h2222);
    stall = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_ex(1, i & 1, i, 1 << (i % 3), i & 1, $urandom);
      drive_id(i & 1, i, i, i, i, i, i, i & 3);
      mem_rdata = $urandom;
      step();
      chk("stall.rval_mm", rval_mm, 32'h1111);
      chk("stall.wdata_mm", wdata_mm, 32'h1111 ^ 32'hA5A5A5A5);
      chk("stall.rval_wb", rval_wb, 32'h2222);
      chk("stall.wb_wr", 32'(wb_wr), 32'h2);
      chk("stall.wb_dest", 32'(wb_dest), 32'd10);
      chk_mux("stall", 1, 2, 0, 0, 0, 0);
    end
    stall = 1'b0; mem_rdata = RDATA;
    drive_ex(0, 0, 0, 0, 0, 32'h3333);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("resume.rval_mm", rval_mm, 32'h3333);
    chk("resume.rval_wb", rval_wb, 32'h1111);
    chk("resume.wb_dest", 32'(wb_dest), 32'd9);
    chk("resume.wb_wr", 32'(wb_wr), 32'h2);
    chk_mux("resume", 0, 0, 0, 0, 0, 0);
    step();
    chk("resume2.wb_wr", 32'(wb_wr), 32'h0);

    // Async reset in the middle of a stall, then a clean first capture.
    drive_ex(1, 0, 4, 2, 0, 32'h4444);
    drive_id(1, 0, 0, 4, 0, 0, 0, 0);
    step();
    chk_mux("prerst", 1, 0, 0, 0, 0, 0);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.rval_mm", rval_mm, 32'h0);
    chk("midrst.wb_wr", 32'(wb_wr), 32'h0);
    chk_mux("midrst", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("postrst.rval_mm", rval_mm, 32'h4444);
    chk("postrst.wb_wr", 32'(wb_wr), 32'h0);
    chk_mux("postrst", 1, 0, 0, 0, 0, 0);
    step();
    chk("postrst2.wb_wr", 32'(wb_wr), 32'h2);
    chk("postrst2.rval_wb", rval_wb, 32'h4444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
